// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the pipeline data-memory arbiter.
package dmem_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-port signals of the data-memory arbiter.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              stall0;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_write, mem_read;
  logic [31:0]       mem_address;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output gnt0, gnt1, stall0, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_read, mem_address, mem_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  gnt0, gnt1, stall0, rvalid0, rvalid1, rdata0, rdata1,
           mem_write, mem_read, mem_address, mem_data
  );

endinterface

// File: rtl/dmem_rd_reg.sv
// Per-port read-data register: captures memory data on a granted read and
// pulses rvalid for one cycle; data holds until the next granted read.
module dmem_rd_reg
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_data_in : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: MEM stage (port 0) has
// priority, debug/loader (port 1) is force-granted after MAX_WAIT denials.
//
//   state  | meaning
//   NORMAL | port 0 has priority, port 1 accumulates wait count
//   FORCE1 | port 1 has priority for one access
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       gnt0, gnt1;
  logic       rd_en0, rd_en1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (!bus.req1 || gnt1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    case (state_q)
      // Switch on the edge where the registered count steps up to MAX_WAIT,
      // so port 1 wins on the very next cycle (MAX_WAIT + 1 worst case).
      NORMAL: if (bus.req1 && !gnt1 && (wait_cnt_q >= MAX_WAIT_C - 4'd1)) state_d = FORCE1;
      FORCE1: if (gnt1 || !bus.req1) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_address = '0;
    bus.mem_data    = '0;
    if (rst_n) begin
      if (state_q == FORCE1) begin
        gnt1 = bus.req1;
        gnt0 = bus.req0 & ~bus.req1;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1 & ~bus.req0;
      end
    end
    if (gnt0) begin
      bus.mem_write   = bus.we0;
      bus.mem_read    = ~bus.we0;
      bus.mem_address = 32'(bus.addr0);
      bus.mem_data    = bus.wdata0;
    end else if (gnt1) begin
      bus.mem_write   = bus.we1;
      bus.mem_read    = ~bus.we1;
      bus.mem_address = 32'(bus.addr1);
      bus.mem_data    = bus.wdata1;
    end
    bus.stall0 = rst_n & bus.req0 & ~gnt0;
    bus.gnt0   = gnt0;
    bus.gnt1   = gnt1;
  end

  assign rd_en0 = gnt0 & ~bus.we0;
  assign rd_en1 = gnt1 & ~bus.we1;

  dmem_rd_reg #(.DATA_W(DATA_W)) u_rd0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en0),
    .rd_data_in (bus.mem_read_data),
    .rvalid     (bus.rvalid0),
    .rdata      (bus.rdata0)
  );

  dmem_rd_reg #(.DATA_W(DATA_W)) u_rd1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en1),
    .rd_data_in (bus.mem_read_data),
    .rvalid     (bus.rvalid1),
    .rdata      (bus.rdata1)
  );

endmodule
